// File: rtl/matrix_stream_engine.sv
// Streaming NxN matrix multiply engine.
// A then B arrive row-major on a valid/ready input stream. C = A*B is computed
// with one multiply-accumulate per cycle. C leaves row-major on a registered
// valid/ready output stream.
module matrix_stream_engine #(
    parameter int DW = 32,
    parameter int N  = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          busy
);

    localparam int NN = N * N;
    localparam int LD = 2 * NN;
    localparam int LW = $clog2(LD);
    localparam int CW = (NN > 1) ? $clog2(NN) : 1;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_DRAIN} state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] ab_mem [LD];   // A at 0..NN-1, B at NN..2NN-1
    logic [DW-1:0] c_mem  [NN];
    logic [LW-1:0] ld_cnt;
    logic [IW-1:0] i_cnt, j_cnt, k_cnt;
    logic [DW-1:0] acc;
    logic [CW-1:0] out_idx, out_nxt;
    logic [LW-1:0] a_idx, b_idx;
    logic [CW-1:0] c_idx;
    logic [DW-1:0] prod, sum;
    logic          last_k, last_j, last_i, load_last, out_hs;

    // MAC operand addressing and wrap-around arithmetic
    always_comb begin
        a_idx     = LW'(i_cnt) * LW'(N) + LW'(k_cnt);
        b_idx     = LW'(NN) + LW'(k_cnt) * LW'(N) + LW'(j_cnt);
        c_idx     = CW'(i_cnt) * CW'(N) + CW'(j_cnt);
        prod      = ab_mem[a_idx] * ab_mem[b_idx];
        sum       = acc + prod;
        last_k    = (k_cnt == IW'(N - 1));
        last_j    = (j_cnt == IW'(N - 1));
        last_i    = (i_cnt == IW'(N - 1));
        load_last = (ld_cnt == LW'(LD - 1));
        out_hs    = out_valid && out_ready;
        out_nxt   = out_idx + CW'(1);
        in_ready  = (state == S_LOAD) && !rst;
        busy      = (state != S_LOAD);
    end

    // Next-state selection
    always_comb begin
        state_nxt = state;
        case (state)
            S_LOAD:    if (in_valid && load_last) state_nxt = S_COMPUTE;
            S_COMPUTE: if (last_k && last_j && last_i) state_nxt = S_DRAIN;
            S_DRAIN:   if (out_hs && out_last) state_nxt = S_LOAD;
            default:   state_nxt = S_LOAD;
        endcase
    end

    // State register; rst and clear both return to LOAD
    always_ff @(posedge clk) begin
        if (rst || clear) state <= S_LOAD;
        else              state <= state_nxt;
    end

    // Datapath: operand capture, accumulation, result storage and output register
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            ld_cnt    <= '0;
            i_cnt     <= '0;
            j_cnt     <= '0;
            k_cnt     <= '0;
            acc       <= '0;
            out_idx   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            for (int unsigned x = 0; x < LD; x++) ab_mem[x] <= '0;
            for (int unsigned x = 0; x < NN; x++) c_mem[x] <= '0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (in_valid) begin
                        ab_mem[ld_cnt] <= in_data;
                        if (load_last) begin
                            ld_cnt <= '0;
                            i_cnt  <= '0;
                            j_cnt  <= '0;
                            k_cnt  <= '0;
                            acc    <= '0;
                        end else begin
                            ld_cnt <= ld_cnt + LW'(1);
                        end
                    end
                end
                S_COMPUTE: begin
                    if (last_k) begin
                        c_mem[c_idx] <= sum;
                        acc          <= '0;
                        k_cnt        <= '0;
                        if (last_j) begin
                            j_cnt <= '0;
                            i_cnt <= last_i ? '0 : i_cnt + IW'(1);
                        end else begin
                            j_cnt <= j_cnt + IW'(1);
                        end
                    end else begin
                        acc   <= sum;
                        k_cnt <= k_cnt + IW'(1);
                    end
                end
                S_DRAIN: begin
                    // First DRAIN cycle loads C[0][0]; after that each handshake
                    // preloads the next element so out_ready=1 streams gap-free.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_data  <= c_mem[out_idx];
                        out_last  <= (out_idx == CW'(NN - 1));
                    end else if (out_ready) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            out_idx   <= '0;
                        end else begin
                            out_idx  <= out_nxt;
                            out_data <= c_mem[out_nxt];
                            out_last <= (out_nxt == CW'(NN - 1));
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_stream_engine.sv
// Self-checking bench for matrix_stream_engine (DW=32, N=3).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_matrix_stream_engine;

    typedef logic [31:0] mat_t [9];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;

    int errors = 0;
    int checks = 0;
    logic [31:0] sb [$];

    matrix_stream_engine #(.DW(32), .N(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Reference product pushed to the scoreboard, then A and B streamed in.
    task automatic send_run(input mat_t a, input mat_t b, input int gap_max);
        logic [31:0] s;
        int          cnt;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                s = '0;
                for (int k = 0; k < 3; k++) s = s + a[i*3+k] * b[k*3+j];
                sb.push_back(s);
            end
        for (int w = 0; w < 18; w++) begin
            if (gap_max > 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(gap_max, 0)) @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = (w < 9) ? a[w] : b[w-9];
            cnt = 0;
            while (!in_ready && cnt < 100) begin
                @(negedge clk);
                cnt++;
            end
            checks++;
            if (!in_ready) begin
                errors++;
                $display("FAIL load_timeout word=%0d in_ready=%b required 1", w, in_ready);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    // Drains up to n results. mode 0: ready always; mode 1: 10-cycle stall at
    // C[1][1] then ready toggles. first_cyc = falling edges until first out_valid.
    task automatic collect(input int n, input int mode, output int first_cyc);
        int          got = 0, cyc = 0, stall = 0;
        bit          tog = 0, held = 0, busy_bad = 0, inr_bad = 0, stab_bad = 0;
        logic [31:0] hd, exp_d;
        logic        hl, exp_l;
        first_cyc = -1;
        while (got < n && cyc < 600) begin
            if (held && (!out_valid || out_data !== hd || out_last !== hl)) stab_bad = 1;
            if (!busy) busy_bad = 1;
            if (in_ready) inr_bad = 1;
            if (out_valid && first_cyc < 0) first_cyc = cyc;
            if (mode == 1 && out_valid && got == 4 && stall < 10) begin
                out_ready = 1'b0;
                stall++;
            end else if (mode == 1 && stall >= 10) begin
                tog = !tog;
                out_ready = tog;
            end else begin
                out_ready = 1'b1;
            end
            if (out_valid && out_ready) begin
                exp_l = (sb.size() == 1);
                exp_d = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF;
                checks++;
                if (out_data !== exp_d || out_last !== exp_l) begin
                    errors++;
                    $display("FAIL out_elem idx=%0d data=%h last=%b required data=%h last=%b",
                             got, out_data, out_last, exp_d, exp_l);
                end
                got++;
            end
            held = out_valid && !out_ready;
            hd   = out_data;
            hl   = out_last;
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        checks++;
        if (got != n) begin
            errors++;
            $display("FAIL drain_timeout got=%0d required %0d", got, n);
        end
        checks++;
        if (busy_bad) begin errors++; $display("FAIL busy_during_run busy dropped, required 1"); end
        checks++;
        if (inr_bad) begin errors++; $display("FAIL in_ready_during_run in_ready rose, required 0"); end
        checks++;
        if (stab_bad) begin errors++; $display("FAIL stall_stable output changed while stalled"); end
        if (n == 9) begin
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL post_drain out_valid=%b busy=%b in_ready=%b required 0 0 1",
                         out_valid, busy, in_ready);
            end
            checks++;
            if (sb.size() != 0) begin
                errors++;
                $display("FAIL sb_empty remaining=%0d required 0", sb.size());
            end
        end
    endtask

    function automatic mat_t seq_up();
        for (int x = 0; x < 9; x++) seq_up[x] = 32'(x + 1);
    endfunction

    function automatic mat_t seq_down();
        for (int x = 0; x < 9; x++) seq_down[x] = 32'(9 - x);
    endfunction

    function automatic mat_t ident();
        for (int x = 0; x < 9; x++) ident[x] = (x % 4 == 0) ? 32'd1 : 32'd0;
    endfunction

    function automatic mat_t all_ones();
        for (int x = 0; x < 9; x++) all_ones[x] = 32'hFFFF_FFFF;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'd0 || out_last !== 1'b0 ||
            busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_state ov=%b od=%h ol=%b busy=%b ir=%b required all 0",
                     out_valid, out_data, out_last, busy, in_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_identity();
        int fc;
        send_run(ident(), seq_up(), 0);
        collect(9, 0, fc);
        checks++;
        if (fc != 28) begin
            errors++;
            $display("FAIL latency first_valid=%0d cycles required 28", fc);
        end
    endtask

    task automatic test_product();
        mat_t exp_c;
        int   fc;
        exp_c = '{30, 24, 18, 84, 69, 54, 138, 114, 90};
        send_run(seq_up(), seq_down(), 0);
        checks++;
        for (int x = 0; x < 9; x++)
            if (sb[x] !== exp_c[x]) begin
                errors++;
                $display("FAIL model_case2 idx=%0d model=%0d required %0d", x, sb[x], exp_c[x]);
                break;
            end
        collect(9, 0, fc);
    endtask

    task automatic test_wrap();
        int fc;
        send_run(all_ones(), all_ones(), 0);
        checks++;
        if (sb[0] !== 32'h0000_0003) begin
            errors++;
            $display("FAIL model_wrap model=%h required 00000003", sb[0]);
        end
        collect(9, 0, fc);
    endtask

    task automatic test_stall();
        int fc;
        send_run(seq_up(), seq_down(), 0);
        collect(9, 1, fc);
    endtask

    task automatic test_clear();
        int fc;
        for (int w = 0; w < 5; w++) begin
            in_valid = 1'b0;
            repeat ($urandom_range(3, 0)) @(negedge clk);
            in_valid = 1'b1;
            in_data  = $urandom | 32'h100;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = 32'h5555_5555;
        clear    = 1'b1;
        @(negedge clk);
        clear    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL after_clear in_ready=%b busy=%b out_valid=%b required 1 0 0",
                     in_ready, busy, out_valid);
        end
        send_run(seq_up(), seq_down(), 3);
        collect(9, 0, fc);
    endtask

    task automatic test_rst_drain();
        int fc;
        send_run(ident(), seq_up(), 0);
        collect(4, 0, fc);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_in_drain out_valid=%b busy=%b in_ready=%b required 0 0 0",
                     out_valid, busy, in_ready);
        end
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_release in_ready=%b required 1", in_ready);
        end
        send_run(ident(), seq_up(), 0);
        collect(9, 0, fc);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_identity();
        test_product();
        test_wrap();
        test_stall();
        test_clear();
        test_rst_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule
